// File: rtl/ct_f_spsram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ct_f_spsram_ctrl_pkg
// Purpose : Shared types and helpers for the single-port SRAM controller.
//           Holds the controller state enum and a depth helper derived
//           from the SRAM address width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ct_f_spsram_ctrl_pkg;

  // Controller states: INIT runs the zero-fill sweep, RUN serves requests.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // Number of SRAM words for a given address width.
  function automatic int unsigned ct_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ct_f_spsram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ct_f_spsram_ctrl
// Purpose : Initiator-side controller for a ct_f_spsram_* single-port SRAM.
//           Converts a valid/ready request port and a valid/ready read
//           response port into the SRAM pin protocol (active-low CEN, GWEN,
//           per-bit WEN, 1-cycle read latency). After reset it optionally
//           sweeps every address writing zero before accepting requests.
// Ports   : CLK, RST           - clock, synchronous active-high reset
//           req_vld/req_rdy    - request handshake
//           req_wr/addr/wdata/wmask - request payload (wmask active-high)
//           rsp_vld/rsp_rdy    - read response handshake
//           rsp_rdata          - read data (straight from sram_q)
//           init_done          - zero-fill sweep complete
//           sram_a/cen/gwen/wen/d - SRAM pins, sram_q - SRAM read data
// Revision: 1.0 - initial release
// ============================================================================
module ct_f_spsram_ctrl
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 144,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  // Last sweep address; the counter is one bit wider so it never wraps.
  localparam logic [ADDR_WIDTH:0] C_INIT_LAST =
    (ADDR_WIDTH+1)'(ct_depth(ADDR_WIDTH) - 1);
  localparam ctrl_state_e C_RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
  localparam logic        C_RST_DONE  = (INIT_EN == 0);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  w_accept;

  always_comb begin
    // Idle pin values double as the reset values of the SRAM interface.
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    sram_a      = '0;
    sram_d      = '0;
    req_rdy     = 1'b0;
    w_accept    = 1'b0;
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rsp_vld_d   = rsp_vld_q;

    // Outputs are forced idle while RST is high, independent of state.
    if (!RST) begin
      case (state_q)
        ST_INIT: begin
          sram_cen   = 1'b0;
          sram_gwen  = 1'b0;
          sram_wen   = '0;
          sram_a     = init_cnt_q[ADDR_WIDTH-1:0];
          init_cnt_d = init_cnt_q + 1'b1;
          rsp_vld_d  = 1'b0;
          if (init_cnt_q == C_INIT_LAST) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
        ST_RUN: begin
          // A held response blocks every request so Q is not disturbed.
          req_rdy  = init_done_q & ~(rsp_vld_q & ~rsp_rdy);
          w_accept = req_vld & req_rdy;
          if (w_accept) begin
            sram_cen  = 1'b0;
            sram_a    = req_addr;
            sram_gwen = ~req_wr;
            sram_wen  = req_wr ? ~req_wmask : '1;
            sram_d    = req_wdata;
          end
          if (w_accept && !req_wr) begin
            rsp_vld_d = 1'b1;
          end else if (rsp_rdy) begin
            rsp_vld_d = 1'b0;
          end
        end
        default: begin
          state_d = C_RST_STATE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= C_RST_STATE;
      init_cnt_q  <= '0;
      init_done_q <= C_RST_DONE;
      rsp_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rsp_vld_q   <= rsp_vld_d;
    end
  end

  assign rsp_vld   = rsp_vld_q;
  assign init_done = init_done_q;
  // The SRAM holds Q while CEN is high, so read data needs no capture flop.
  assign rsp_rdata = sram_q;

endmodule
`default_nettype wire

// File: tb/tb_ct_f_spsram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ct_f_spsram_ctrl
// Purpose : Self-checking bench for ct_f_spsram_ctrl with a behavioural
//           single-port SRAM and a scoreboard of expected read data.
// Ports   : none (testbench top)
// Revision: 1.0 - initial release
// ============================================================================
module tb_ct_f_spsram_ctrl;

  localparam int AW    = 7;
  localparam int DW    = 144;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] exp_mem  [DEPTH];
  logic [DW-1:0] exp_q    [$];

  always #5 CLK = ~CLK;

  ct_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1)) dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural SRAM: 1-cycle read, Q held while CEN is high.
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else
        sram_q <= sram_mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      exp_q.delete();
    end else begin
      if (rsp_vld && rsp_rdy) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", {{(DW-1){1'b0}}, rsp_vld}, '0);
        else chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
      if (init_done) begin
        if (req_vld && req_rdy) begin
          chk("acc_pins", {sram_cen, sram_gwen, sram_a}, {1'b0, ~req_wr, req_addr});
          chk("acc_wen", sram_wen, req_wr ? ~req_wmask : {DW{1'b1}});
          chk("acc_d", sram_d, req_wdata);
          if (req_wr)
            exp_mem[req_addr] = (exp_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
          else
            exp_q.push_back(exp_mem[req_addr]);
        end else begin
          chk("idle_pins", {sram_cen, sram_gwen, &sram_wen}, 3'b111);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] wm);
    logic ok;
    ok = 1'b0;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_wmask = wm;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (req_rdy) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    chk("accept", {{(DW-1){1'b0}}, ok}, 1);
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    req_vld = 1'b0; req_wr = 1'b0; req_wdata = '0; req_wmask = '0;
  endtask

  logic [DW-1:0] a5, held;
  int            n;

  initial begin
    a5 = {18{8'hA5}};
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pins", {sram_cen, sram_gwen, &sram_wen, |sram_a, |sram_d}, 5'b11100);
    chk("rst_flags", {init_done, req_rdy, rsp_vld}, 3'b000);

    // Zero-fill sweep.
    @(posedge CLK); #1 RST = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge CLK);
      chk("sweep_a", sram_a, k);
      chk("sweep_pins", {sram_cen, sram_gwen, |sram_wen, |sram_d, req_rdy, init_done}, 0);
    end
    @(negedge CLK);
    chk("init_done", {init_done, req_rdy}, 2'b11);

    // Full write, then read back.
    @(posedge CLK); #1;
    issue(1'b1, 7'd5, a5, '1);
    issue(1'b0, 7'd5, '0, '0);
    idle();
    @(negedge CLK);
    chk("rd5_vld", rsp_vld, 1);

    // Masked write of low byte, then read back.
    @(posedge CLK); #1;
    issue(1'b1, 7'd5, '1, {{(DW-8){1'b0}}, 8'hFF});
    issue(1'b0, 7'd5, '0, '0);
    idle();
    @(negedge CLK);
    chk("mask_rdata", rsp_rdata, {a5[DW-1:8], 8'hFF});

    // Stalled read response.
    @(posedge CLK); #1 rsp_rdy = 1'b0;
    issue(1'b0, 7'd3, '0, '0);
    idle();
    @(negedge CLK);
    held = rsp_rdata;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge CLK);
      chk("stall", {rsp_vld, req_rdy, sram_cen}, 3'b101);
      chk("stall_rdata", rsp_rdata, held);
      if (c < 3) begin @(posedge CLK); #1; end
    end
    @(posedge CLK); #1 rsp_rdy = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("stall_clear", rsp_vld, 0);

    // Distinct data in 1 and 2, then back-to-back reads 0..3.
    @(posedge CLK); #1;
    issue(1'b1, 7'd1, {18{8'h11}}, '1);
    issue(1'b1, 7'd2, {18{8'h22}}, '1);
    idle();
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(i);
      @(negedge CLK);
      chk("b2b_rdy", req_rdy, 1);
      if (i > 0) chk("b2b_vld", rsp_vld, 1);
      @(posedge CLK); #1;
    end
    idle();
    @(negedge CLK);
    chk("b2b_last_vld", rsp_vld, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("b2b_end_vld", rsp_vld, 0);

    // Reset in the middle of the sweep.
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    for (int k = 0; k <= 60; k++) @(negedge CLK);
    chk("mid_a60", sram_a, 60);
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst", {sram_cen, init_done}, 2'b10);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("mid_restart_a", sram_a, 0);
    n = 0;
    while (!init_done && n < 300) begin
      n++;
      @(negedge CLK);
    end
    chk("mid_sweep_len", n, 128);

    // Sweep must have zeroed address 5 again.
    @(posedge CLK); #1;
    issue(1'b0, 7'd5, '0, '0);
    idle();
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ct_f_spsram_ctrl.md
Name: ct_f_spsram_ctrl

Overview:
Initiator-side controller for the single-port FPGA SRAM models (ct_f_spsram_*). It converts a valid/ready request port and a valid/ready read-response port into the SRAM pin protocol: active-low CEN, GWEN and per-bit WEN, with 1-cycle read latency and Q held stable while CEN is high. After reset it sweeps every address once, writing zero, so array contents are defined before the first functional access. It sits between a cache/buffer pipeline and one ct_f_spsram_* instance.

Parameters:
ADDR_WIDTH, 7, SRAM address width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 144, SRAM data width.
INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = ready immediately after reset.

Ports:
CLK  in  1  clock.
RST  in  1  synchronous reset, active-high.
req_vld  in  1  request valid.
req_rdy  out  1  request accepted when req_vld & req_rdy.
req_wr  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  access address.
req_wdata  in  DATA_WIDTH  write data.
req_wmask  in  DATA_WIDTH  active-high per-bit write enable.
rsp_vld  out  1  read data valid.
rsp_rdy  in  1  consumer accepts read data.
rsp_rdata  out  DATA_WIDTH  read data (equals sram_q).
init_done  out  1  zero-fill sweep complete.
sram_a  out  ADDR_WIDTH  to SRAM A.
sram_cen  out  1  to SRAM CEN, active-low.
sram_gwen  out  1  to SRAM GWEN, active-low.
sram_wen  out  DATA_WIDTH  to SRAM WEN, active-low per bit.
sram_d  out  DATA_WIDTH  to SRAM D.
sram_q  in  DATA_WIDTH  from SRAM Q.

Behaviour:
- Clock is CLK. Reset is synchronous, active-high, on RST.
- Reset values: state=INIT (RUN if INIT_EN=0), init_cnt=0, init_done=0 (1 if INIT_EN=0), rsp_vld=0, req_rdy=0.
- SRAM pins while RST=1: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- States: INIT and RUN.
- INIT, every cycle: sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=init_cnt; init_cnt increments by 1.
- INIT exit: on the cycle init_cnt = 2**ADDR_WIDTH-1, state goes to RUN and init_done=1. Sweep takes exactly 2**ADDR_WIDTH cycles after RST falls. init_cnt is ADDR_WIDTH+1 bits wide; there is no wrap.
- INIT: req_rdy=0, rsp_vld=0.
- RST asserted mid-INIT: sweep restarts from address 0.
- RUN: req_rdy = init_done & !(rsp_vld & !rsp_rdy). A stalled response blocks all new requests, reads and writes alike, so Q is never disturbed while data is being held.
- RUN, on accept (req_vld & req_rdy), same cycle, combinational:
  - sram_cen=0, sram_a=req_addr.
  - sram_gwen = !req_wr.
  - sram_wen = req_wr ? ~req_wmask : all 1.
  - sram_d=req_wdata.
- RUN, no accept: sram_cen=1, sram_gwen=1, sram_wen=all 1. The SRAM holds its address, so Q stays stable.
- Read latency: rsp_vld=1 in the cycle after an accepted read; rsp_rdata=sram_q.
- rsp_vld next-state:
  - set if a read is accepted this cycle;
  - else cleared if rsp_rdy=1;
  - else held.
- Back-to-back reads with rsp_rdy=1 run at 1 per cycle.
- Writes produce no response.
- Write with req_wmask=0: still asserts CEN and GWEN; no bit changes.
- Read following a write to the same address in the next cycle returns the new data.
- Accept with req_vld=1 while a response is stalled cannot occur, because req_rdy=0 in that case.

Decomposition:
- Package ct_f_spsram_ctrl_pkg: state enum (INIT, RUN) and localparam function for depth from ADDR_WIDTH.
- No sub-module. The init counter and response flag are small enough to live inline.

Test Plan:
- Reset release, ADDR_WIDTH=7 -> sram_cen=0, sram_gwen=0, sram_a counts 0..127 over 128 cycles with sram_d=0; init_done=1 and req_rdy=1 on cycle 128.
- Write addr 5, data 0xA5..A5, mask all 1s; then read addr 5 -> sram_wen=0 on the write cycle; rsp_vld=1 one cycle after the read accept with rsp_rdata=0xA5..A5.
- Masked write to addr 5, data all 1s, mask=0xFF (low 8 bits); then read -> rsp_rdata = 0xA5..A5 with bits[7:0]=0xFF.
- Read addr 3 with rsp_rdy=0 held for 4 cycles -> rsp_vld stays 1, rsp_rdata stable, req_rdy=0, sram_cen=1 throughout; rsp_rdy=1 -> rsp_vld clears next cycle.
- Reads to addrs 0,1,2,3 back-to-back with rsp_rdy=1 -> 4 consecutive rsp_vld cycles with data in order, no bubbles.
- RST pulsed at init_cnt=60 -> sram_a restarts at 0; init_done rises 128 cycles after RST falls.
